pitch_shift_sequencer: RTL and testbench

//  Frame-level controller for the spectral pitch filter. On each FFT frame it latches a pitch, streams the 256

---
 rtl/pitch_pkg.sv | 23 ++
 rtl/delay_pipe.sv | 31 +++
 rtl/pitch_shift_sequencer.sv | 136 +++++++++++++
 tb/tb_pitch_shift_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pitch_pkg.sv
// Shared sizes, pitch constants and FSM encoding for the pitch-shift frame sequencer.
package pitch_pkg;

  localparam int N_BINS = 256;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 10;

  localparam logic [7:0] PITCH_UNITY = 8'd127;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    STREAM,
    FLUSH,
    DONE
  } seq_state_t;

  // Counter value at which the filter output carries output bin 0.
  function automatic logic [CNT_W-1:0] write_base(input int rd_latency);
    write_base = CNT_W'(N_BINS - 1 + rd_latency);
  endfunction

endpackage

// File: rtl/delay_pipe.sv
// Fixed-latency register chain (DEPTH cycles); DEPTH=0 is a plain wire.
module delay_pipe #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_pipe
      logic [W-1:0] stage [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/pitch_shift_sequencer.sv
// Frame controller for the spectral pitch filter: latch pitch, settle, stream 256 bins, flush, done.
// All outputs are flops decoded from next-state, so nothing combinational reaches them from inputs.
module pitch_shift_sequencer
  import pitch_pkg::*;
#(
  parameter int RD_LATENCY = 1,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_ready,
  input  logic              ifft_ready,
  input  logic [7:0]        pitch_in,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              in_zero,
  output logic [7:0]        pitch,
  output logic [ADDR_W-1:0] freq_bin,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              frame_done,
  output logic              overrun
);

  localparam logic [CNT_W-1:0] BASE   = write_base(RD_LATENCY);
  localparam logic [CNT_W-1:0] LAST   = BASE + CNT_W'(N_BINS - 1);
  localparam logic [CNT_W-1:0] END_RD = CNT_W'(N_BINS);
  localparam int               SW     = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  seq_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SW-1:0]    settle_cnt, settle_nxt;
  logic             pending, pending_nxt;
  logic             overrun_nxt;
  logic             start;
  logic             streaming_nxt;
  logic             wr_nxt;
  logic             zero_raw;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    settle_nxt  = settle_cnt;
    pending_nxt = pending;
    overrun_nxt = overrun;
    start       = 1'b0;

    case (state)
      IDLE: begin
        if ((frame_ready || pending) && ifft_ready) begin
          start       = 1'b1;
          state_nxt   = SETTLE;
          pending_nxt = 1'b0;
          cnt_nxt     = '0;
          settle_nxt  = '0;
        end else if (frame_ready) begin
          pending_nxt = 1'b1;
        end
      end
      SETTLE: begin
        if (settle_cnt == SW'(SETTLE_CYC - 1)) state_nxt = STREAM;
        else                                   settle_nxt = settle_cnt + 1'b1;
      end
      STREAM: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == END_RD - 1'b1) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (cnt == LAST) begin
          state_nxt = DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // DONE still counts as busy: a frame arriving there must queue, not start.
    if (state != IDLE && frame_ready) begin
      if (pending) overrun_nxt = 1'b1;
      else         pending_nxt = 1'b1;
    end
  end

  assign streaming_nxt = (state_nxt == STREAM) || (state_nxt == FLUSH);
  assign wr_nxt        = streaming_nxt && (cnt_nxt >= BASE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      settle_cnt <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      pitch      <= PITCH_UNITY;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      zero_raw   <= 1'b0;
      wr_en      <= 1'b0;
      freq_bin   <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      settle_cnt <= settle_nxt;
      pending    <= pending_nxt;
      overrun    <= overrun_nxt;
      if (start) pitch <= pitch_in;
      rd_en      <= streaming_nxt && (cnt_nxt < END_RD);
      rd_addr    <= (streaming_nxt && (cnt_nxt < END_RD)) ? cnt_nxt[ADDR_W-1:0] : '0;
      zero_raw   <= streaming_nxt && (cnt_nxt >= END_RD);
      wr_en      <= wr_nxt;
      freq_bin   <= wr_nxt ? ADDR_W'(cnt_nxt - BASE) : '0;
      busy       <= (state_nxt != IDLE);
      frame_done <= (state_nxt == DONE);
    end
  end

  // Zero-forcing must line up with RAM data, not with the read request.
  delay_pipe #(
    .W     (1),
    .DEPTH (RD_LATENCY)
  ) u_zero_dly (
    .clk  (clk),
    .rst  (reset),
    .din  (zero_raw),
    .dout (in_zero)
  );

  assign wr_addr = freq_bin;

endmodule

// File: tb/tb_pitch_shift_sequencer.sv
// Bench: RAM + delay-line filter model around the sequencer, scoreboard of IFFT writes.
module tb_pitch_shift_sequencer;

  localparam int FRAME_CYC = 516;  // frame_ready cycle through the frame_done cycle, inclusive

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_ready = 1'b0;
  logic       ifft_ready = 1'b1;
  logic [7:0] pitch_in = 8'd127;
  logic       rd_en, in_zero, wr_en, busy, frame_done, overrun;
  logic [7:0] rd_addr, pitch, freq_bin, wr_addr;

  always #5 clk = ~clk;

  pitch_shift_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .frame_ready (frame_ready),
    .ifft_ready  (ifft_ready),
    .pitch_in    (pitch_in),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .in_zero     (in_zero),
    .pitch       (pitch),
    .freq_bin    (freq_bin),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    logic [7:0] pitch_in;
    bit         toggle;
    int         shift;
    logic [7:0] exp_pitch;
  } vec_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         tcyc = 0;
  int         done_cnt = 0;
  int         frame_len = 0;
  int         pitch_moves = 0;
  logic       busy_q = 1'b0;
  logic [7:0] pitch_lat = 8'd0;
  logic [7:0] rd_data = 8'hA5;
  logic [7:0] fft_ram [256];
  logic [7:0] hist [1024];

  always @(posedge clk) if (rd_en) rd_data <= fft_ram[rd_addr];

  // Filter model: input history per cycle, output delayed 128+pitch, negative sources gated by freq_bin.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] x, y;
    int         src;
    tcyc++;
    x = in_zero ? 8'd0 : rd_data;
    hist[tcyc % 1024] = x;
    src = int'(freq_bin) + 127 - int'(pitch);
    y = (src < 0) ? 8'd0 : hist[(tcyc + 1024 - 128 - int'(pitch)) % 1024];
    if (reset) begin
      busy_q    = 1'b0;
      frame_len = 0;
    end else begin
      if (wr_en) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: write to bin %0d data %0d, nothing expected", wr_addr, y);
        end else begin
          e = sb.pop_front();
          if (wr_addr !== e.addr || y !== e.data) begin
            errors++;
            $display("FAIL sb_write: got bin %0d data %0d, expected bin %0d data %0d",
                     wr_addr, y, e.addr, e.data);
          end
        end
      end
      if (busy && !busy_q) begin
        frame_len   = 2;
        pitch_lat   = pitch;
        pitch_moves = 0;
      end else if (busy) begin
        frame_len++;
        if (pitch !== pitch_lat) pitch_moves++;
      end
      if (frame_done) begin
        done_cnt++;
        checks++;
        if (frame_len != FRAME_CYC) begin
          errors++;
          $display("FAIL frame_len: got %0d cycles, expected %0d", frame_len, FRAME_CYC);
        end
        checks++;
        if (pitch_moves != 0) begin
          errors++;
          $display("FAIL pitch_hold: pitch moved %0d times during frame, expected 0", pitch_moves);
        end
      end
      busy_q = busy;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input int shift);
    for (int k = 0; k < 256; k++) begin
      exp_t e;
      int   s;
      s      = k + shift;
      e.addr = 8'(k);
      e.data = (s >= 0 && s <= 255) ? fft_ram[s] : 8'd0;
      sb.push_back(e);
    end
  endtask

  task automatic pulse_frame();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
  endtask

  task automatic wait_frames(input int target, input bit toggle, input logic [7:0] p);
    for (int i = 0; i < 1500; i++) begin
      if (done_cnt >= target) break;
      if (toggle) pitch_in = (pitch_in == p) ? 8'd200 : p;
      tick();
    end
    check("frame_timeout", 32'(done_cnt >= target), 32'd1);
    pitch_in = p;
  endtask

  task automatic wait_rd_addr(input logic [7:0] a);
    int n;
    n = 0;
    while (!(rd_en && rd_addr == a) && n < 1000) begin
      tick();
      n++;
    end
    check("rd_addr_timeout", 32'(rd_en && rd_addr == a), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs [4];
    int   d0, bad;

    for (int i = 0; i < 1024; i++) hist[i] = 8'h5A;
    for (int k = 0; k < 256; k++) fft_ram[k] = 8'(k);

    vecs[0] = '{8'd127, 1'b0,   0, 8'd127};
    vecs[1] = '{8'd137, 1'b0, -10, 8'd137};
    vecs[2] = '{8'd117, 1'b0,  10, 8'd117};
    vecs[3] = '{8'd127, 1'b1,   0, 8'd127};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_en", 32'(rd_en), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_pitch", 32'(pitch), 32'd127);
    check("rst_in_zero", 32'(in_zero), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // Table frames: unity, shift down, shift up, unity with pitch_in toggling
    foreach (vecs[v]) begin
      d0       = done_cnt;
      pitch_in = vecs[v].pitch_in;
      push_frame(vecs[v].shift);
      pulse_frame();
      wait_frames(d0 + 1, vecs[v].toggle, vecs[v].pitch_in);
      repeat (3) tick();
      check("sb_drained", 32'(sb.size()), 32'd0);
      check("pitch_latched", 32'(pitch), 32'(vecs[v].exp_pitch));
      check("idle_after_frame", 32'(busy), 32'd0);
    end

    // Frame held off by ifft_ready, starts on the rising edge of ifft_ready
    d0         = done_cnt;
    ifft_ready = 1'b0;
    pitch_in   = 8'd127;
    push_frame(0);
    pulse_frame();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy || rd_en) bad++;
      tick();
    end
    check("held_idle", 32'(bad), 32'd0);
    ifft_ready = 1'b1;
    tick();
    check("start_on_ifft_ready", 32'(busy), 32'd1);
    wait_frames(d0 + 1, 1'b0, 8'd127);
    repeat (3) tick();
    check("held_sb_drained", 32'(sb.size()), 32'd0);

    // Pending frame and overrun
    d0 = done_cnt;
    push_frame(0);
    pulse_frame();
    wait_rd_addr(8'd50);
    push_frame(0);
    pulse_frame();
    check("overrun_after_pending", 32'(overrun), 32'd0);
    wait_rd_addr(8'd60);
    pulse_frame();
    check("overrun_set", 32'(overrun), 32'd1);
    wait_frames(d0 + 2, 1'b0, 8'd127);
    repeat (3) tick();
    check("pending_sb_drained", 32'(sb.size()), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    check("no_third_frame", 32'(done_cnt), 32'(d0 + 2));

    // Reset mid-flush at C=300 (output bin 44)
    pitch_in = 8'd137;
    push_frame(-10);
    pulse_frame();
    bad = 0;
    while (!(wr_en && wr_addr == 8'd44) && bad < 1000) begin
      tick();
      bad++;
    end
    check("reach_c300", 32'(wr_en && wr_addr == 8'd44), 32'd1);
    d0    = done_cnt;
    reset = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_pitch", 32'(pitch), 32'd127);
    check("abort_overrun", 32'(overrun), 32'd0);
    tick();
    reset = 1'b0;
    repeat (600) tick();
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    check("abort_stays_idle", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
